bim_table_ctrl: RTL and testbench
=================================

BIM_TABLE_CTRL -- requirements
Module: bim_table_ctrl

Interface
REQ-001 SHALL have parameter INIT_CTR, default 2'b01, giving the counter value written to every entry during init (weakly not-taken).
REQ-002 SHALL have port clock  input  1  single clock for all logic; the table memory's R0_clk and W0_clk are tied to this clock at top level.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports pred_valid input 1, pred_ready output 1, pred_idx input 11  prediction lookup request.
REQ-005 SHALL have ports resp_valid output 1, resp_ctr output 2, resp_taken output 1  prediction response.
REQ-006 SHALL have ports upd_valid input 1, upd_ready output 1, upd_idx input 11, upd_taken input 1, upd_old_ctr input 2  resolved-branch update.
REQ-007 SHALL have ports mem_R0_addr output 11, mem_R0_en output 1, mem_R0_data input 2  to the 2048x2 table read port (1-cycle read latency).
REQ-008 SHALL have ports mem_W0_addr output 11, mem_W0_en output 1, mem_W0_data output 2  to the table write port.
REQ-009 SHALL have port init_done  output 1  high once the table sweep is complete.

Function
REQ-010 SHALL implement FSM states INIT and RUN; INIT -> RUN after writing address 2047; RUN is terminal until reset.
REQ-011 In INIT SHALL assert mem_W0_en with mem_W0_addr = init counter (0..2047, +1 per cycle) and mem_W0_data = INIT_CTR; the sweep takes exactly 2048 cycles.
REQ-012 SHALL drive pred_ready = upd_ready = init_done = (state == RUN); requests are ignored in INIT.
REQ-013 A prediction accepted in cycle N (pred_valid & pred_ready) SHALL drive mem_R0_en=1, mem_R0_addr=pred_idx in cycle N and assert resp_valid for exactly cycle N+1.
REQ-014 resp_ctr SHALL equal mem_R0_data, except when a write to the same index is issued in cycle N, in which case resp_ctr SHALL equal that write's data (write-to-read bypass).
REQ-015 resp_taken SHALL equal resp_ctr[1]; resp_ctr SHALL be 2'b00 whenever resp_valid=0 (never X).
REQ-016 An update accepted in cycle N SHALL be registered into stage U1 and written in cycle N+1: mem_W0_en=1, mem_W0_addr=idx, mem_W0_data=new_ctr.
REQ-017 new_ctr SHALL be saturating: taken -> min(old+1, 3); not-taken -> max(old-1, 0); 2-bit arithmetic with no wrap (3 taken stays 3; 0 not-taken stays 0).
REQ-018 old SHALL be upd_old_ctr, except when U1 is valid in cycle N with the same index, in which case old SHALL be U1's new_ctr (back-to-back same-index chaining).
REQ-019 Back-to-back updates to different indices SHALL be accepted every cycle at full rate (one write per cycle).
REQ-020 Prediction and update SHALL be accepted in the same cycle independently; memory read and write ports have no mutual interaction beyond REQ-014.
REQ-021 mem_W0_en SHALL be 0 in RUN whenever U1 is empty; mem_R0_en SHALL be 0 when no prediction is accepted.

Reset
REQ-022 With reset_n=0 at a clock edge: state=INIT, init counter=0, U1 valid=0, resp_valid=0, resp_ctr=0, init_done=0, pred_ready=upd_ready=0.
REQ-023 During reset cycles mem_W0_en and mem_R0_en SHALL be 0; the sweep begins in the first cycle after reset_n returns to 1.
REQ-024 Reset asserted mid-sweep or mid-RUN SHALL discard any in-flight update and response and restart the sweep at address 0.

Verification
REQ-025 Release reset -> 2048 consecutive writes of 2'b01 to addresses 0..2047; init_done rises in cycle 2049; no ready before then.
REQ-026 After init, predict idx 5 -> resp_valid next cycle, resp_ctr=2'b01, resp_taken=0.
REQ-027 Updates idx 7 taken with old=01 in cycles N, N+1, N+2 -> writes 10, 11, 11 in N+1..N+3; subsequent predict idx 7 returns 11, resp_taken=1.
REQ-028 Update idx 9 not-taken old=00 -> write 00 (saturation); update idx 9 not-taken old=11 -> write 10.
REQ-029 Update idx 3 taken old=01 in cycle N; predict idx 3 in cycle N+1 -> resp_ctr=10 via bypass.
REQ-030 Assert reset_n=0 at sweep address 1000 and with U1 valid -> no write from U1, sweep restarts at 0, init_done=0 for 2048 cycles.

Source files
------------

// File: rtl/bim_table_ctrl_if.sv
// ============================================================================
// Module      : bim_table_ctrl_if
// Description : Request, response and table-memory signal bundle for the
//               bimodal predictor table controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bim_table_ctrl_if;
    logic        pred_valid;
    logic        pred_ready;
    logic [10:0] pred_idx;

    logic        resp_valid;
    logic [1:0]  resp_ctr;
    logic        resp_taken;

    logic        upd_valid;
    logic        upd_ready;
    logic [10:0] upd_idx;
    logic        upd_taken;
    logic [1:0]  upd_old_ctr;

    logic [10:0] mem_R0_addr;
    logic        mem_R0_en;
    logic [1:0]  mem_R0_data;

    logic [10:0] mem_W0_addr;
    logic        mem_W0_en;
    logic [1:0]  mem_W0_data;

    logic        init_done;

    modport slave (
        input  pred_valid, pred_idx,
        input  upd_valid, upd_idx, upd_taken, upd_old_ctr,
        input  mem_R0_data,
        output pred_ready, resp_valid, resp_ctr, resp_taken, upd_ready,
        output mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data,
        output init_done
    );

    modport master (
        output pred_valid, pred_idx,
        output upd_valid, upd_idx, upd_taken, upd_old_ctr,
        output mem_R0_data,
        input  pred_ready, resp_valid, resp_ctr, resp_taken, upd_ready,
        input  mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data,
        input  init_done
    );
endinterface

`default_nettype wire

// File: rtl/bim_table_ctrl.sv
// ============================================================================
// Module      : bim_table_ctrl
// Description : 2048-entry 2-bit bimodal table controller: init sweep, lookup
//               with write bypass, and saturating update with chaining.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bim_table_ctrl #(
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic              clock,
    input  logic              reset_n,
    bim_table_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [10:0] LAST_ADDR = 11'd2047;

    state_t      state_q, state_d;
    logic [10:0] init_cnt_q, init_cnt_d;
    logic        u1_valid_q, u1_valid_d;
    logic [10:0] u1_idx_q, u1_idx_d;
    logic [1:0]  u1_ctr_q, u1_ctr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        byp_hit_q, byp_hit_d;
    logic [1:0]  byp_ctr_q, byp_ctr_d;

    logic        run;
    logic        pred_accept;
    logic        upd_accept;
    logic [1:0]  old_ctr;
    logic [1:0]  new_ctr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= 11'd0;
            u1_valid_q   <= 1'b0;
            u1_idx_q     <= 11'd0;
            u1_ctr_q     <= 2'b00;
            resp_valid_q <= 1'b0;
            byp_hit_q    <= 1'b0;
            byp_ctr_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            u1_valid_q   <= u1_valid_d;
            u1_idx_q     <= u1_idx_d;
            u1_ctr_q     <= u1_ctr_d;
            resp_valid_q <= resp_valid_d;
            byp_hit_q    <= byp_hit_d;
            byp_ctr_q    <= byp_ctr_d;
        end
    end

    // Outputs are gated by reset_n so a reset cycle issues no memory traffic
    // and any in-flight update or response is dropped immediately.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        u1_valid_d   = 1'b0;
        u1_idx_d     = u1_idx_q;
        u1_ctr_d     = u1_ctr_q;
        resp_valid_d = 1'b0;
        byp_hit_d    = 1'b0;
        byp_ctr_d    = byp_ctr_q;

        run         = (state_q == ST_RUN) && reset_n;
        pred_accept = bus.pred_valid && run;
        upd_accept  = bus.upd_valid && run;

        old_ctr = (u1_valid_q && (u1_idx_q == bus.upd_idx)) ? u1_ctr_q : bus.upd_old_ctr;
        if (bus.upd_taken) begin
            new_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
        end else begin
            new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
        end

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 11'd1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (upd_accept) begin
            u1_valid_d = 1'b1;
            u1_idx_d   = bus.upd_idx;
            u1_ctr_d   = new_ctr;
        end

        // The memory returns pre-write data on a same-cycle same-index
        // collision, so remember the value being written instead.
        if (pred_accept) begin
            resp_valid_d = 1'b1;
            byp_hit_d    = u1_valid_q && (u1_idx_q == bus.pred_idx);
            byp_ctr_d    = u1_ctr_q;
        end
    end

    assign bus.pred_ready  = run;
    assign bus.upd_ready   = run;
    assign bus.init_done   = run;

    assign bus.mem_R0_en   = pred_accept;
    assign bus.mem_R0_addr = bus.pred_idx;

    assign bus.mem_W0_en   = reset_n && ((state_q == ST_INIT) || u1_valid_q);
    assign bus.mem_W0_addr = (state_q == ST_INIT) ? init_cnt_q : u1_idx_q;
    assign bus.mem_W0_data = (state_q == ST_INIT) ? INIT_CTR : u1_ctr_q;

    assign bus.resp_valid  = resp_valid_q && reset_n;
    assign bus.resp_ctr    = bus.resp_valid ? (byp_hit_q ? byp_ctr_q : bus.mem_R0_data) : 2'b00;
    assign bus.resp_taken  = bus.resp_ctr[1];

endmodule

`default_nettype wire

// File: tb/tb_bim_table_ctrl.sv
// ============================================================================
// Module      : tb_bim_table_ctrl
// Description : Self-checking bench: table memory model plus a reference of
//               the predictor table contents and expected per-cycle outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bim_table_ctrl;

    localparam logic [1:0] INIT_CTR = 2'b01;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    bim_table_ctrl_if bus ();

    bim_table_ctrl #(.INIT_CTR(INIT_CTR)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2048x2 table with one-cycle registered read (read returns old data).
    logic [1:0] mem [0:2047];
    logic [1:0] mem_rd;
    assign bus.mem_R0_data = mem_rd;
    always @(posedge clk) begin
        if (bus.mem_R0_en) mem_rd <= mem[bus.mem_R0_addr];
        if (bus.mem_W0_en) mem[bus.mem_W0_addr] <= bus.mem_W0_data;
    end

    // Reference: table contents and what the next cycle must show.
    logic [1:0]  ref_tbl [0:2047];
    bit          m_run;
    int          m_cnt;
    bit          m_wv;
    logic [10:0] m_widx;
    logic [1:0]  m_wdata;
    bit          m_rv;
    logic [1:0]  m_rctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rn, input bit pv, input logic [10:0] pidx,
                       input bit uv, input logic [10:0] uidx, input bit ut,
                       input logic [1:0] uold);
        bit         e_rdy, e_wen, e_ren;
        int         e_waddr, e_wdata, old, nw;
        logic [1:0] e_rctr;
        rst_n           = rn;
        bus.pred_valid  = pv;
        bus.pred_idx    = pidx;
        bus.upd_valid   = uv;
        bus.upd_idx     = uidx;
        bus.upd_taken   = ut;
        bus.upd_old_ctr = uold;
        #1;
        e_rdy   = rn && m_run;
        e_ren   = e_rdy && pv;
        e_wen   = rn && (!m_run || m_wv);
        e_waddr = !m_run ? m_cnt : int'(m_widx);
        e_wdata = !m_run ? int'(INIT_CTR) : int'(m_wdata);
        e_rctr  = (rn && m_rv) ? m_rctr : 2'b00;
        chk("pred_ready", bus.pred_ready, e_rdy);
        chk("upd_ready",  bus.upd_ready,  e_rdy);
        chk("init_done",  bus.init_done,  e_rdy);
        chk("r0_en",      bus.mem_R0_en,  e_ren);
        if (e_ren) chk("r0_addr", bus.mem_R0_addr, pidx);
        chk("w0_en",      bus.mem_W0_en,  e_wen);
        if (e_wen) begin
            chk("w0_addr", bus.mem_W0_addr, e_waddr);
            chk("w0_data", bus.mem_W0_data, e_wdata);
        end
        chk("resp_valid", bus.resp_valid, rn && m_rv);
        chk("resp_ctr",   bus.resp_ctr,   e_rctr);
        chk("resp_taken", bus.resp_taken, e_rctr[1]);

        if (!rn) begin
            m_run = 0; m_cnt = 0; m_wv = 0; m_rv = 0;
        end else if (!m_run) begin
            ref_tbl[m_cnt] = INIT_CTR;
            m_cnt++;
            if (m_cnt == 2048) m_run = 1;
            m_wv = 0; m_rv = 0;
        end else begin
            m_rv   = pv;
            m_rctr = ref_tbl[pidx];
            if (uv) begin
                old = (m_wv && m_widx == uidx) ? int'(m_wdata) : int'(uold);
                nw  = ut ? old + 1 : old - 1;
                if (nw > 3) nw = 3;
                if (nw < 0) nw = 0;
                ref_tbl[uidx] = nw[1:0];
                m_wv = 1; m_widx = uidx; m_wdata = nw[1:0];
            end else begin
                m_wv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 11'd0, 0, 11'd0, 0, 2'b00);
    endtask

    // Random requests during the sweep must all be ignored.
    task automatic sweep_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(1, 1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom),
                1'($urandom), 2'($urandom));
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom),
                1'($urandom), 2'($urandom));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_run = 0; m_cnt = 0; m_wv = 0; m_rv = 0;
        m_widx = '0; m_wdata = '0; m_rctr = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 2'($urandom);
            ref_tbl[i] = 2'bxx;
        end
        rst_n = 1'b0;
        bus.pred_valid = 0; bus.pred_idx = '0;
        bus.upd_valid = 0; bus.upd_idx = '0; bus.upd_taken = 0; bus.upd_old_ctr = '0;
        @(posedge clk);
        #1;

        reset_cycles(3);
        sweep_cycles(2048);
        idle(1);

        cyc(1, 1, 11'd5, 0, 11'd0, 0, 2'b00);
        idle(1);

        cyc(1, 0, 11'd0, 1, 11'd7, 1, 2'b01);
        cyc(1, 0, 11'd0, 1, 11'd7, 1, 2'b01);
        cyc(1, 0, 11'd0, 1, 11'd7, 1, 2'b01);
        idle(1);
        cyc(1, 1, 11'd7, 0, 11'd0, 0, 2'b00);
        idle(1);

        cyc(1, 0, 11'd0, 1, 11'd9, 0, 2'b00);
        idle(1);
        cyc(1, 0, 11'd0, 1, 11'd9, 0, 2'b11);
        idle(1);

        cyc(1, 0, 11'd0, 1, 11'd3, 1, 2'b01);
        cyc(1, 1, 11'd3, 0, 11'd0, 0, 2'b00);
        idle(1);

        cyc(1, 1, 11'd20, 1, 11'd21, 1, 2'b10);
        cyc(1, 1, 11'd21, 1, 11'd22, 0, 2'b10);
        cyc(1, 1, 11'd22, 1, 11'd23, 1, 2'b11);
        idle(1);

        for (int i = 0; i < 400; i++)
            cyc(1, 1'($urandom), 11'($urandom_range(0, 15)), 1'($urandom),
                11'($urandom_range(0, 15)), 1'($urandom), 2'($urandom));
        idle(1);

        // Reset with an update sitting in U1 and a response pending.
        cyc(1, 1, 11'd100, 1, 11'd100, 1, 2'b01);
        reset_cycles(2);
        sweep_cycles(1000);
        reset_cycles(1);
        sweep_cycles(2048);
        idle(1);

        cyc(1, 1, 11'd100, 0, 11'd0, 0, 2'b00);
        cyc(1, 1, 11'd7, 0, 11'd0, 0, 2'b00);
        idle(1);
        for (int i = 0; i < 100; i++)
            cyc(1, 1'($urandom), 11'($urandom_range(0, 7)), 1'($urandom),
                11'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
